uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receive-side frame engine. Deserializes the 8N1/8O1/8E1 frames produced by the transmit datapath and its parity generator, checks parity and the stop bit, and presents the byte with status flags.
- Sits between the RX pin synchronizer and the receive holding register or FIFO.
- Timed by an external oversampling tick from the shared baud generator.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, 8..32).
- DATA_BITS, 8, data bits per frame; only 8 is supported.

Ports:
- clock, input, 1, system clock; all flops rise on the posedge.
- reset, input, 1, asynchronous, active-high reset.
- rx_in, input, 1, raw serial line; idle level is 1.
- baud_tick, input, 1, one-clock pulse at OVERSAMPLE × baud rate.
- parity_type, input, 2, 00/11 = no parity, 01 = odd, 10 = even (same encoding as the TX side).
- data_out, output, 8, last received byte.
- data_valid, output, 1, one-clock pulse when a frame completes.
- parity_error, output, 1, qualified by data_valid.
- stop_error, output, 1, framing error, qualified by data_valid.
- rx_busy, output, 1, high while a frame is in progress (START through STOP).

Behaviour:
- Reset (async, active-high):
  - synchronizer flops = 1, state = IDLE, counters = 0.
  - data_out = 8'h00; data_valid, parity_error, stop_error, rx_busy = 0.
  - Reset mid-frame aborts the frame immediately; no data_valid is produced.
- rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- tick_cnt counts baud_tick pulses within a bit. bit_cnt is 3 bits wide.
- IDLE:
  - On rx_s = 0, go to START and clear tick_cnt. rx_busy = 1 from this cycle.
- START:
  - On the (OVERSAMPLE/2)-th tick, sample rx_s.
  - If rx_s = 1, it is a false start: go to IDLE with no outputs.
  - If rx_s = 0, latch parity_type into par_q, clear tick_cnt and bit_cnt, and go to DATA.
  - par_q is used for the whole frame; parity_type changes mid-frame are ignored.
- DATA:
  - Every OVERSAMPLE ticks (the bit centre), shift rx_s into shreg[7], shifting right. Data is LSB first.
  - After the 8th sample (bit_cnt wraps 7→0), go to PARITY if par_q ∈ {01, 10}, otherwise go to STOP.
- PARITY:
  - Sample p at the bit centre.
  - perr = (^shreg ^ p) != 1 for odd; perr = (^shreg ^ p) != 0 for even.
- STOP:
  - Sample at the bit centre; serr = ~rx_s.
  - On the clock after that sample tick:
    - data_out = shreg.
    - data_valid = 1 for exactly one clock.
    - parity_error = perr (0 when no parity).
    - stop_error = serr.
  - Next state: IDLE if rx_s = 1, else BREAK. rx_busy drops in the same cycle.
- BREAK:
  - Wait until rx_s = 1, then go to IDLE.
  - A held-low line yields exactly one frame with stop_error = 1, not repeated frames.
- data_out holds its value until the next data_valid. parity_error and stop_error are 0 whenever data_valid = 0.
- Returning to IDLE at the stop-bit centre permits back-to-back frames with no idle gap.
- baud_tick is ignored in IDLE and BREAK. Counter wrap: tick_cnt counts 0..OVERSAMPLE-1.
- Latency: data_valid comes 1 clock after the stop-bit centre tick, about 9.5 bit times after the start edge (10.5 with parity), plus 2 synchronizer clocks.

Test Plan:
- No-parity frame, parity_type = 00, byte 8'hA5 (line 0,1,0,1,0,0,1,0,1, then stop 1) → one data_valid pulse, data_out = A5, parity_error = 0, stop_error = 0, rx_busy low after the pulse.
- Odd parity, 8'h07 with parity bit 0 → parity_error = 0. Repeat with parity bit 1 → parity_error = 1, data_out = 07.
- Even parity, 8'h00 with parity bit 0 → no error. Change parity_type to 01 mid-frame → still checked as even, no error.
- Glitch: line low for 4 ticks, then high → no data_valid, state returns to IDLE, rx_busy pulses then clears. A following valid frame 8'h3C is received correctly.
- Framing/break: frame 8'h55 with stop = 0, line held low for 40 bit times → exactly one data_valid with stop_error = 1. No further frames until the line rises, then the next frame 8'hC3 is received clean.
- Back-to-back frames 8'h01, 8'hFE with no idle gap → two data_valid pulses about 10 bit times apart. Assert reset mid-way through a third frame → all outputs return to reset values, no third data_valid.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: deserializes 8N1/8O1/8E1 frames, checks parity and stop bit.
// Latency: data_valid 1 clock after the stop-bit centre tick (~9.5/10.5 bit times + 2 sync clocks).
// No backpressure: data_valid is a single-clock strobe that must be consumed when it fires.
//
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   rx_in             - raw serial line (idle high), synchronized internally
//   baud_tick         - one-clock pulse at OVERSAMPLE x baud rate
//   parity_type       - 00/11 none, 01 odd, 10 even (latched at start of frame)
//   data_out          - last received byte, held until the next data_valid
//   data_valid        - one-clock pulse per completed frame
//   parity_error      - parity mismatch, qualified by data_valid
//   stop_error        - framing error (stop bit low), qualified by data_valid
//   rx_busy           - high from start detection through the stop bit
module uart_rx_frame #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_in,
   input  logic                 baud_tick,
   input  logic [1:0]           parity_type,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_error,
   output logic                 stop_error,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 rx_m;
   logic                 rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           par_q;
   logic                 perr;
   logic                 half_tick;
   logic                 centre_tick;
   logic                 par_en;
   logic                 start_ok;
   logic                 shift_en;
   logic                 par_sample;
   logic                 stop_sample;

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
      end
   end

   assign half_tick   = baud_tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
   assign centre_tick = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
   assign par_en      = (par_q == 2'b01) || (par_q == 2'b10);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!rx_s) state_nxt = S_START;
         S_START:  if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (centre_tick && (bit_cnt == 3'(DATA_BITS - 1)))
                      state_nxt = par_en ? S_PARITY : S_STOP;
         S_PARITY: if (centre_tick) state_nxt = S_STOP;
         // Leaving at the stop-bit centre lets a following start bit be caught with no idle gap.
         S_STOP:   if (centre_tick) state_nxt = rx_s ? S_IDLE : S_BREAK;
         S_BREAK:  if (rx_s) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output / strobe decode
   always_comb begin
      rx_busy     = 1'b0;
      start_ok    = 1'b0;
      shift_en    = 1'b0;
      par_sample  = 1'b0;
      stop_sample = 1'b0;
      case (state)
         S_START: begin
            rx_busy  = 1'b1;
            start_ok = half_tick && !rx_s;
         end
         S_DATA: begin
            rx_busy  = 1'b1;
            shift_en = centre_tick;
         end
         S_PARITY: begin
            rx_busy    = 1'b1;
            par_sample = centre_tick;
         end
         S_STOP: begin
            rx_busy     = 1'b1;
            stop_sample = centre_tick;
         end
         default: ;
      endcase
   end

   // Bit timing, shift register and parity tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_q    <= 2'b00;
         perr     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: tick_cnt <= '0;
            // Restart the count at the start-bit centre so later samples land on bit centres.
            S_START: if (baud_tick) tick_cnt <= half_tick ? '0 : tick_cnt + 1'b1;
            S_DATA, S_PARITY, S_STOP:
               if (baud_tick) tick_cnt <= centre_tick ? '0 : tick_cnt + 1'b1;
            default: ;
         endcase

         if (start_ok) begin
            par_q   <= parity_type;
            bit_cnt <= '0;
            perr    <= 1'b0;
         end

         if (shift_en) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (par_sample) begin
            if (par_q == 2'b01) perr <= ((^shreg) ^ rx_s) != 1'b1;
            else                perr <= ((^shreg) ^ rx_s) != 1'b0;
         end
      end
   end

   // Registered frame result; flags are forced low outside the valid strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= stop_sample;
         parity_error <= stop_sample & perr;
         stop_error   <= stop_sample & ~rx_s;
         if (stop_sample) data_out <= shreg;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: drives serial frames and compares results to a frame-level model.
// Latency: results are collected by a monitor and compared after each frame has been sent.
// Backpressure: none; every data_valid strobe is captured into a queue.
module tb_uart_rx_frame;

   localparam int OS       = 16;
   localparam int DIV      = 4;
   localparam int BIT_CLKS = OS * DIV;

   logic       clock;
   logic       reset;
   logic       rx_in;
   logic       baud_tick;
   logic [1:0] parity_type;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_error;
   logic       stop_error;
   logic       rx_busy;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int qual_viol = 0;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       se;
      int         cyc;
   } obs_t;

   obs_t obs_q[$];

   logic [7:0] r_d;
   logic [1:0] r_pt;
   logic       r_pb;
   logic       r_sb;
   obs_t       o1;
   obs_t       o2;

   uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_in        (rx_in),
      .baud_tick    (baud_tick),
      .parity_type  (parity_type),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .parity_error (parity_error),
      .stop_error   (stop_error),
      .rx_busy      (rx_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin : tickgen
      int k;
      k = 0;
      baud_tick = 1'b0;
      forever begin
         @(negedge clock);
         baud_tick = (k == 0);
         k = (k + 1) % DIV;
      end
   end

   // Capture every completed frame and watch that flags never appear without data_valid.
   always @(negedge clock) begin
      cyc++;
      if (data_valid) obs_q.push_back('{data_out, parity_error, stop_error, cyc});
      if (!data_valid && (parity_error || stop_error)) qual_viol++;
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: observed no finish, expected finish within 60000 clocks");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: parity error from the count of ones across data plus parity bit.
   function automatic logic model_perr(input logic [7:0] d, input logic [1:0] pt, input logic pbit);
      int ones;
      ones = int'(pbit);
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      if (pt == 2'b01) return (ones % 2) != 1;
      if (pt == 2'b10) return (ones % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic has_parity(input logic [1:0] pt);
      return (pt == 2'b01) || (pt == 2'b10);
   endfunction

   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (BIT_CLKS) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                             input logic pbit, input logic stopb);
      parity_type = pt;
      drive_bit(1'b0);
      parity_type = pt_mid;
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (has_parity(pt)) drive_bit(pbit);
      drive_bit(stopb);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic se);
      int   waited;
      obs_t o;
      waited = 0;
      while (obs_q.size() == 0 && waited < 2 * BIT_CLKS) begin
         @(negedge clock);
         waited++;
      end
      chk({tag, "_present"}, (obs_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         chk({tag, "_data"}, o.d, d);
         chk({tag, "_perr"}, o.pe, pe);
         chk({tag, "_serr"}, o.se, se);
      end
      chk({tag, "_single"}, obs_q.size(), 0);
      chk({tag, "_busy_low"}, rx_busy, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      rx_in       = 1'b1;
      parity_type = 2'b00;
      repeat (5) @(negedge clock);
      chk("rst_data", data_out, 8'h00);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_perr", parity_error, 1'b0);
      chk("rst_serr", stop_error, 1'b0);
      chk("rst_busy", rx_busy, 1'b0);
      reset = 1'b0;
      repeat (BIT_CLKS) @(negedge clock);

      // No parity
      send_frame(8'hA5, 2'b00, 2'b00, 1'b0, 1'b1);
      expect_frame("a5_nopar", 8'hA5, 1'b0, 1'b0);

      // Odd parity, good then bad parity bit
      send_frame(8'h07, 2'b01, 2'b01, 1'b0, 1'b1);
      expect_frame("odd_ok", 8'h07, model_perr(8'h07, 2'b01, 1'b0), 1'b0);
      send_frame(8'h07, 2'b01, 2'b01, 1'b1, 1'b1);
      expect_frame("odd_bad", 8'h07, model_perr(8'h07, 2'b01, 1'b1), 1'b0);

      // Even parity with parity_type changed mid-frame
      send_frame(8'h00, 2'b10, 2'b01, 1'b0, 1'b1);
      expect_frame("even_mid", 8'h00, model_perr(8'h00, 2'b10, 1'b0), 1'b0);
      parity_type = 2'b00;

      // Glitch shorter than half a bit
      rx_in = 1'b0;
      repeat (8) @(negedge clock);
      chk("glitch_busy", rx_busy, 1'b1);
      repeat (8) @(negedge clock);
      rx_in = 1'b1;
      repeat (BIT_CLKS) @(negedge clock);
      chk("glitch_idle", rx_busy, 1'b0);
      chk("glitch_nodv", obs_q.size(), 0);
      send_frame(8'h3C, 2'b00, 2'b00, 1'b0, 1'b1);
      expect_frame("after_glitch", 8'h3C, 1'b0, 1'b0);

      // Framing error followed by a long break
      send_frame(8'h55, 2'b00, 2'b00, 1'b0, 1'b0);
      repeat (40 * BIT_CLKS) @(negedge clock);
      chk("break_busy", rx_busy, 1'b0);
      expect_frame("break", 8'h55, 1'b0, 1'b1);
      rx_in = 1'b1;
      repeat (BIT_CLKS) @(negedge clock);
      send_frame(8'hC3, 2'b00, 2'b00, 1'b0, 1'b1);
      expect_frame("after_break", 8'hC3, 1'b0, 1'b0);

      // Random frames against the model
      for (int n = 0; n < 8; n++) begin
         r_d  = 8'($urandom);
         r_pt = 2'($urandom_range(0, 3));
         r_pb = 1'($urandom_range(0, 1));
         r_sb = ($urandom_range(0, 3) != 0);
         send_frame(r_d, r_pt, r_pt, r_pb, r_sb);
         expect_frame($sformatf("rand%0d", n), r_d, model_perr(r_d, r_pt, r_pb), !r_sb);
         rx_in = 1'b1;
         repeat (BIT_CLKS) @(negedge clock);
      end

      // Back-to-back frames with no idle gap
      parity_type = 2'b00;
      send_frame(8'h01, 2'b00, 2'b00, 1'b0, 1'b1);
      send_frame(8'hFE, 2'b00, 2'b00, 1'b0, 1'b1);
      chk("b2b_count", obs_q.size(), 2);
      if (obs_q.size() >= 2) begin
         o1 = obs_q.pop_front();
         o2 = obs_q.pop_front();
         chk("b2b_d0", o1.d, 8'h01);
         chk("b2b_d1", o2.d, 8'hFE);
         chk("b2b_flags", {o1.pe, o1.se, o2.pe, o2.se}, 4'b0000);
         chk("b2b_gap", o2.cyc - o1.cyc, 10 * BIT_CLKS);
      end

      // Reset in the middle of a third frame
      rx_in = 1'b0;
      repeat (3 * BIT_CLKS) @(negedge clock);
      chk("mid_busy", rx_busy, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_data", data_out, 8'h00);
      chk("mid_rst_valid", data_valid, 1'b0);
      chk("mid_rst_flags", {parity_error, stop_error}, 2'b00);
      chk("mid_rst_busy", rx_busy, 1'b0);
      rx_in = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      repeat (12 * BIT_CLKS) @(negedge clock);
      chk("mid_no_third", obs_q.size(), 0);
      chk("flag_qualify", qual_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
